// File: rtl/tile_buf_reader_pkg.sv
`default_nettype none
//==============================================================================
// Module : tile_buf_reader_pkg
// Brief  : Tile geometry, widths and plane enum shared with the tile-writer.
// Rev    : 1.0  initial release
//==============================================================================
package tile_buf_reader_pkg;

    localparam int ADDR_W      = 14;
    localparam int PLANE_WORDS = 4096;
    localparam int ROW_WORDS   = 64;
    localparam int NUM_COMP    = 3;
    localparam int SMP_W       = 16;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 2 * BYTE_W;
    localparam int DOUT_W      = 17;
    localparam int IDX_W       = $clog2(PLANE_WORDS);
    localparam int COL_W       = $clog2(ROW_WORDS);

    typedef enum logic [1:0] {
        COMP_Y = 2'd0,
        COMP_U = 2'd1,
        COMP_V = 2'd2
    } comp_e;

    typedef struct packed {
        comp_e comp;
        logic  sol_word;
        logic  eol_word;
    } rd_tag_t;

    typedef struct packed {
        rd_tag_t           tag;
        logic [WORD_W-1:0] word;
    } fifo_ent_t;

    localparam int FIFO_W = $bits(fifo_ent_t);

    function automatic logic [ADDR_W-1:0] plane_addr(input comp_e comp,
                                                     input logic [IDX_W-1:0] idx);
        return ADDR_W'(comp) * ADDR_W'(PLANE_WORDS) + ADDR_W'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_buf_reader_if.sv
`default_nettype none
//==============================================================================
// Module : tile_buf_reader_if
// Brief  : Serial sample stream with row/plane framing toward the DWT row engine.
// Rev    : 1.0  initial release
//==============================================================================
interface tile_buf_reader_if;
    import tile_buf_reader_pkg::*;

    logic [SMP_W-1:0] smp_o;
    logic             smp_vld;
    logic             smp_rdy;
    logic             smp_sol;
    logic             smp_eol;
    comp_e            smp_comp;

    modport master (
        output smp_o,
        output smp_vld,
        output smp_sol,
        output smp_eol,
        output smp_comp,
        input  smp_rdy
    );

    modport slave (
        input  smp_o,
        input  smp_vld,
        input  smp_sol,
        input  smp_eol,
        input  smp_comp,
        output smp_rdy
    );
endinterface
`default_nettype wire

// File: rtl/tile_rd_fifo2.sv
`default_nettype none
//==============================================================================
// Module : tile_rd_fifo2
// Brief  : Two-entry FIFO for read words plus tags; same-cycle push/pop allowed.
// Rev    : 1.0  initial release
//==============================================================================
module tile_rd_fifo2
    import tile_buf_reader_pkg::*;
#(
    parameter int DATA_W = FIFO_W
) (
    input  wire logic              clk_dwt,
    input  wire logic              rst_syn,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_push_data,
    input  wire logic              i_pop,
    output logic      [DATA_W-1:0] o_pop_data,
    output logic                   o_empty,
    output logic      [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk_dwt) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk_dwt) begin
        if (rst_syn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == 2'd0);
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/tile_buf_reader.sv
`default_nettype none
//==============================================================================
// Module : tile_buf_reader
// Brief  : Reads one ping-pong tile bank (Y,U,V planes) and streams sign-extended
//          samples with row/plane markers to the DWT row engine.
// Rev    : 1.0  initial release
//==============================================================================
module tile_buf_reader
    import tile_buf_reader_pkg::*;
(
    input  wire logic              clk_dwt,
    input  wire logic              rst_syn,
    input  wire logic              start,
    input  wire logic              bank_sel,
    output logic      [ADDR_W-1:0] addrb_o1,
    output logic                   enb_o1,
    input  wire logic [DOUT_W-1:0] doutb_o1,
    output logic      [ADDR_W-1:0] addrb_o2,
    output logic                   enb_o2,
    input  wire logic [DOUT_W-1:0] doutb_o2,
    tile_buf_reader_if.master      smp_if,
    output logic                   busy,
    output logic                   tile_done,
    output logic                   ovf_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_start_acc;
    logic               r_bank;
    logic [IDX_W-1:0]   r_word_idx;
    comp_e              r_comp;
    logic               r_inflight;
    rd_tag_t            r_inflight_tag;
    logic               r_half;
    logic               r_tile_done;
    logic               r_ovf;

    logic [1:0]         w_fifo_count;
    logic               w_fifo_empty;
    fifo_ent_t          w_head;
    fifo_ent_t          w_push_ent;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_plane_end;
    logic               w_last_issue;
    logic               w_accept;
    logic               w_pop;
    logic               w_last_pop;
    logic [ADDR_W-1:0]  w_addr;
    logic [BYTE_W-1:0]  w_byte;
    logic               w_unused_dout;

    // Words queued plus the one in flight may never exceed the FIFO depth.
    assign w_credit_ok  = (w_fifo_count + {1'b0, r_inflight}) < 2'd2;
    assign w_issue      = (r_state == ST_RUN) && w_credit_ok;
    assign w_plane_end  = (r_word_idx == IDX_W'(PLANE_WORDS - 1));
    assign w_last_issue = w_issue && w_plane_end && (r_comp == comp_e'(2'(NUM_COMP - 1)));
    assign w_addr       = plane_addr(r_comp, r_word_idx);

    assign w_accept   = !w_fifo_empty && smp_if.smp_rdy;
    assign w_pop      = w_accept && r_half;
    assign w_last_pop = (r_state == ST_DRAIN) && w_pop && !r_inflight && (w_fifo_count == 2'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_start_acc = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_dwt) begin
        if (rst_syn) begin
            r_state        <= ST_IDLE;
            r_bank         <= 1'b0;
            r_word_idx     <= '0;
            r_comp         <= COMP_Y;
            r_inflight     <= 1'b0;
            r_inflight_tag <= '0;
            r_half         <= 1'b0;
            r_tile_done    <= 1'b0;
            r_ovf          <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_inflight  <= w_issue;
            r_tile_done <= w_last_pop;
            if (start && (r_state != ST_IDLE)) begin
                r_ovf <= 1'b1;
            end
            if (w_accept) begin
                r_half <= ~r_half;
            end
            if (w_issue) begin
                r_inflight_tag <= '{comp:     r_comp,
                                    sol_word: (r_word_idx[COL_W-1:0] == '0),
                                    eol_word: (r_word_idx[COL_W-1:0] == COL_W'(ROW_WORDS - 1))};
            end
            if (w_start_acc) begin
                r_bank     <= bank_sel;
                r_word_idx <= '0;
                r_comp     <= COMP_Y;
            end else if (w_issue) begin
                r_word_idx <= r_word_idx + IDX_W'(1);
                if (w_plane_end && !w_last_issue) begin
                    r_comp <= comp_e'(r_comp + 2'd1);
                end
            end
        end
    end

    // Bank data is valid exactly one cycle after its enable, so capture on r_inflight.
    assign w_push_ent    = '{tag:  r_inflight_tag,
                             word: r_bank ? doutb_o2[WORD_W-1:0] : doutb_o1[WORD_W-1:0]};
    assign w_unused_dout = doutb_o1[DOUT_W-1] ^ doutb_o2[DOUT_W-1];

    tile_rd_fifo2 #(
        .DATA_W      (FIFO_W)
    ) u_fifo (
        .clk_dwt     (clk_dwt),
        .rst_syn     (rst_syn),
        .i_push      (r_inflight),
        .i_push_data (w_push_ent),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_byte = r_half ? w_head.word[WORD_W-1:BYTE_W] : w_head.word[BYTE_W-1:0];

    always_comb begin
        smp_if.smp_vld  = !w_fifo_empty;
        smp_if.smp_o    = '0;
        smp_if.smp_sol  = 1'b0;
        smp_if.smp_eol  = 1'b0;
        smp_if.smp_comp = COMP_Y;
        if (!w_fifo_empty) begin
            smp_if.smp_o    = {{(SMP_W - BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            smp_if.smp_sol  = w_head.tag.sol_word && !r_half;
            smp_if.smp_eol  = w_head.tag.eol_word && r_half;
            smp_if.smp_comp = w_head.tag.comp;
        end
    end

    assign enb_o1    = w_issue && !r_bank;
    assign enb_o2    = w_issue && r_bank;
    assign addrb_o1  = enb_o1 ? w_addr : '0;
    assign addrb_o2  = enb_o2 ? w_addr : '0;
    assign busy      = (r_state != ST_IDLE);
    assign tile_done = r_tile_done;
    assign ovf_err   = r_ovf;

endmodule
`default_nettype wire
